// File: rtl/mips32_trace_buffer.sv
// mips32_trace_buffer
// Captures retired instructions (PC, instruction word, ALU result) from the
// MIPS32 single-cycle core into a show-ahead FIFO. Capture can start at once
// or on a PC match, and stops after a programmable record count. The stored
// records drain out through a valid/ready stream.
module mips32_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trig_mode,
  input  logic [31:0]       trig_pc,
  input  logic [CNT_W-1:0]  cap_len,
  input  logic              retire,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       alu_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_alu,
  output logic [ADDR_W:0]   fill_level,
  output logic [CNT_W-1:0]  drop_count,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  state_t             state_q, state_d;
  logic [31:0]        trig_pc_q, trig_pc_d;
  logic [CNT_W-1:0]   cap_len_q, cap_len_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [31:0]        out_instr_q, out_instr_d;
  logic [31:0]        out_alu_q, out_alu_d;

  logic [31:0]        mem_pc_q    [DEPTH];
  logic [31:0]        mem_instr_q [DEPTH];
  logic [31:0]        mem_alu_q   [DEPTH];

  logic full;
  logic pop;
  logic trig_hit;
  logic push_cand;
  logic push_acc;
  logic drop;

  // Push/pop qualification: a full FIFO still accepts when it pops that cycle
  always_comb begin
    full      = (count_q == FULL_CNT);
    pop       = out_valid && out_ready;
    trig_hit  = (state_q == ARMED) && retire && (pc_in == trig_pc_q);
    push_cand = ((state_q == CAPTURE) && retire) || trig_hit;
    push_acc  = push_cand && (!full || pop);
    drop      = push_cand && !push_acc;
  end

  // Capture control: arming, trigger match and record-count termination
  always_comb begin
    state_d   = state_q;
    trig_pc_d = trig_pc_q;
    cap_len_d = cap_len_q;
    acc_d     = acc_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d   = trig_mode ? ARMED : CAPTURE;
          trig_pc_d = trig_pc;
          cap_len_d = cap_len;
          acc_d     = '0;
        end
      end
      ARMED: begin
        if (trig_hit) state_d = CAPTURE;
      end
      default: begin
        state_d = state_q;
      end
    endcase
    if (push_acc) begin
      acc_d = acc_q + CNT_W'(1);
      if ((cap_len_q != '0) && (acc_d == cap_len_q)) state_d = DONE;
    end
    if (drop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  // FIFO bookkeeping and the registered show-ahead head record
  always_comb begin
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d    = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d     = count_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_alu_d   = out_alu_q;
    if (push_acc && !pop) count_d = count_q + 1'b1;
    else if (!push_acc && pop) count_d = count_q - 1'b1;
    if (count_d != '0) begin
      if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
        out_pc_d    = pc_in;
        out_instr_d = instr_in;
        out_alu_d   = alu_in;
      end else begin
        out_pc_d    = mem_pc_q[rd_ptr_d];
        out_instr_d = mem_instr_q[rd_ptr_d];
        out_alu_d   = mem_alu_q[rd_ptr_d];
      end
    end
  end

  // Control and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      trig_pc_q   <= '0;
      cap_len_q   <= '0;
      acc_q       <= '0;
      drop_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_alu_q   <= '0;
    end else begin
      state_q     <= state_d;
      trig_pc_q   <= trig_pc_d;
      cap_len_q   <= cap_len_d;
      acc_q       <= acc_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_alu_q   <= out_alu_d;
    end
  end

  // Record storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_pc_q[wr_ptr_q]    <= pc_in;
      mem_instr_q[wr_ptr_q] <= instr_in;
      mem_alu_q[wr_ptr_q]   <= alu_in;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;
  assign out_alu    = out_alu_q;
  assign fill_level = count_q;
  assign drop_count = drop_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_mips32_trace_buffer.sv
// tb_mips32_trace_buffer
// Directed bench for the trace buffer: expected records are queued as the
// stimulus retires them and compared as they drain from the FIFO.
module tb_mips32_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              arm;
  logic              trigMode;
  logic [31:0]       trigPc;
  logic [CNT_W-1:0]  capLen;
  logic              retire;
  logic [31:0]       pcIn;
  logic [31:0]       instrIn;
  logic [31:0]       aluIn;
  logic              outValid;
  logic              outReady;
  logic [31:0]       outPc;
  logic [31:0]       outInstr;
  logic [31:0]       outAlu;
  logic [ADDR_W:0]   fillLevel;
  logic [CNT_W-1:0]  dropCount;
  logic [1:0]        stateOut;

  int passCount;
  int totalCount;
  logic [31:0] expQ[$];
  logic [31:0] lastPc;

  mips32_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trig_mode  (trigMode),
    .trig_pc    (trigPc),
    .cap_len    (capLen),
    .retire     (retire),
    .pc_in      (pcIn),
    .instr_in   (instrIn),
    .alu_in     (aluIn),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_pc     (outPc),
    .out_instr  (outInstr),
    .out_alu    (outAlu),
    .fill_level (fillLevel),
    .drop_count (dropCount),
    .state_out  (stateOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] aluOf(input logic [31:0] pc);
    return pc + 32'h0000_1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] pc);
    retire  = r;
    pcIn    = pc;
    instrIn = instrOf(pc);
    aluIn   = aluOf(pc);
    tick();
    retire  = 1'b0;
  endtask

  task automatic armCapture(input logic mode, input logic [31:0] tpc, input logic [CNT_W-1:0] len);
    arm      = 1'b1;
    trigMode = mode;
    trigPc   = tpc;
    capLen   = len;
    tick();
    arm      = 1'b0;
  endtask

  task automatic checkHead(input string tag);
    logic [31:0] e;
    checkOutput({tag, "_valid"}, {31'b0, outValid}, 32'd1);
    if (expQ.size() > 0) begin
      e = expQ[0];
      checkOutput({tag, "_pc"}, outPc, e);
      checkOutput({tag, "_instr"}, outInstr, instrOf(e));
      checkOutput({tag, "_alu"}, outAlu, aluOf(e));
    end else begin
      checkOutput({tag, "_queue_empty"}, 32'd1, 32'd0);
    end
  endtask

  task automatic drainAll(input int n, input string tag);
    outReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      checkHead(tag);
      if (expQ.size() > 0) lastPc = expQ.pop_front();
      tick();
    end
    outReady = 1'b0;
    checkOutput({tag, "_empty_valid"}, {31'b0, outValid}, 32'd0);
    checkOutput({tag, "_empty_fill"}, {27'b0, fillLevel}, 32'd0);
  endtask

  initial begin
    int guard;
    logic phase;
    passCount  = 0;
    totalCount = 0;
    lastPc     = '0;
    reset      = 1'b1;
    arm        = 1'b0;
    trigMode   = 1'b0;
    trigPc     = '0;
    capLen     = '0;
    retire     = 1'b0;
    pcIn       = '0;
    instrIn    = '0;
    aluIn      = '0;
    outReady   = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_state", {30'b0, stateOut}, 32'd0);
    checkOutput("rst_fill", {27'b0, fillLevel}, 32'd0);
    checkOutput("rst_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rst_pc", outPc, 32'd0);
    checkOutput("rst_drop", {16'b0, dropCount}, 32'd0);

    // Immediate capture, cap_len=3; later cap_len change must be ignored
    armCapture(1'b0, 32'h0, 16'd3);
    capLen = 16'd0;
    checkOutput("imm_state_cap", {30'b0, stateOut}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) expQ.push_back(32'(i * 4));
      applyStimulus(1'b1, 32'(i * 4));
      if (i == 0) checkOutput("imm_latency_valid", {31'b0, outValid}, 32'd1);
      if (i == 2) checkOutput("imm_state_done", {30'b0, stateOut}, 32'd3);
    end
    checkOutput("imm_fill", {27'b0, fillLevel}, 32'd3);
    checkOutput("imm_drop", {16'b0, dropCount}, 32'd0);
    checkOutput("imm_state", {30'b0, stateOut}, 32'd3);
    drainAll(3, "imm");

    // PC trigger from DONE; trig_pc change after arm must be ignored
    armCapture(1'b1, 32'h10, 16'd2);
    trigPc = 32'h99;
    checkOutput("trg_state_armed", {30'b0, stateOut}, 32'd1);
    applyStimulus(1'b0, 32'h10);
    checkOutput("trg_noretire", {30'b0, stateOut}, 32'd1);
    applyStimulus(1'b1, 32'h08);
    applyStimulus(1'b1, 32'h0C);
    checkOutput("trg_still_armed", {30'b0, stateOut}, 32'd1);
    checkOutput("trg_none_stored", {27'b0, fillLevel}, 32'd0);
    expQ.push_back(32'h10);
    applyStimulus(1'b1, 32'h10);
    checkOutput("trg_state_cap", {30'b0, stateOut}, 32'd2);
    expQ.push_back(32'h14);
    applyStimulus(1'b1, 32'h14);
    checkOutput("trg_state_done", {30'b0, stateOut}, 32'd3);
    applyStimulus(1'b1, 32'h18);
    checkOutput("trg_fill", {27'b0, fillLevel}, 32'd2);
    drainAll(2, "trg");

    // Overflow: unlimited capture, 20 retires into 16 entries
    armCapture(1'b0, 32'h0, 16'd0);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) expQ.push_back(32'h100 + 32'(i * 4));
      applyStimulus(1'b1, 32'h100 + 32'(i * 4));
    end
    checkOutput("ovf_fill", {27'b0, fillLevel}, 32'd16);
    checkOutput("ovf_drop", {16'b0, dropCount}, 32'd4);
    checkOutput("ovf_head", outPc, 32'h100);

    // Full FIFO with simultaneous pop and push for 5 cycles
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkHead("fullpp");
      lastPc = expQ.pop_front();
      expQ.push_back(32'h200 + 32'(i * 4));
      applyStimulus(1'b1, 32'h200 + 32'(i * 4));
      checkOutput("fullpp_fill", {27'b0, fillLevel}, 32'd16);
      checkOutput("fullpp_drop", {16'b0, dropCount}, 32'd4);
    end
    outReady = 1'b0;

    // Arm while capturing is ignored
    armCapture(1'b1, 32'h0, 16'd1);
    checkOutput("arm_ignored", {30'b0, stateOut}, 32'd2);

    // Backpressure: out_ready toggles, outputs hold while stalled
    guard = 0;
    phase = 1'b0;
    while ((expQ.size() > 0) && (guard < 200)) begin
      outReady = phase;
      if (!phase) begin
        tick();
        checkOutput("bp_stall_valid", {31'b0, outValid}, 32'd1);
        checkOutput("bp_stall_pc", outPc, expQ[0]);
        checkOutput("bp_stall_alu", outAlu, aluOf(expQ[0]));
      end else begin
        checkHead("bp");
        lastPc = expQ.pop_front();
        tick();
      end
      phase = ~phase;
      guard++;
    end
    outReady = 1'b0;
    checkOutput("bp_drain_timeout", 32'(expQ.size()), 32'd0);
    checkOutput("bp_empty_valid", {31'b0, outValid}, 32'd0);
    checkOutput("bp_empty_fill", {27'b0, fillLevel}, 32'd0);
    checkOutput("bp_hold_pc", outPc, lastPc);
    checkOutput("bp_hold_instr", outInstr, instrOf(lastPc));

    // Mid-capture reset after 5 pushes
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h300 + 32'(i * 4));
    checkOutput("mrst_pre_fill", {27'b0, fillLevel}, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mrst_fill", {27'b0, fillLevel}, 32'd0);
    checkOutput("mrst_valid", {31'b0, outValid}, 32'd0);
    checkOutput("mrst_state", {30'b0, stateOut}, 32'd0);
    checkOutput("mrst_drop", {16'b0, dropCount}, 32'd0);
    checkOutput("mrst_idle_noretire", {27'b0, fillLevel}, 32'd0);
    armCapture(1'b0, 32'h0, 16'd2);
    expQ.push_back(32'h400);
    applyStimulus(1'b1, 32'h400);
    expQ.push_back(32'h404);
    applyStimulus(1'b1, 32'h404);
    checkOutput("mrst_recap_state", {30'b0, stateOut}, 32'd3);
    checkOutput("mrst_recap_fill", {27'b0, fillLevel}, 32'd2);
    drainAll(2, "mrst");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
